// File: rtl/uart_pkg.sv
// uart_pkg: state codes shared by the UART receiver and transmitter, plus the
// default bit period. The PARITY code only appears on the wire of a block
// built with UART_RX_PARITY_EN.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 16;

  typedef enum logic [3:0] {
    ST_START     = 4'h0,
    ST_BIT_0     = 4'h1,
    ST_BIT_1     = 4'h2,
    ST_BIT_2     = 4'h3,
    ST_BIT_3     = 4'h4,
    ST_BIT_4     = 4'h5,
    ST_BIT_5     = 4'h6,
    ST_BIT_6     = 4'h7,
    ST_BIT_7     = 4'h8,
    ST_PARITY    = 4'h9,
    ST_STOP      = 4'ha,
    ST_WAIT_HIGH = 4'hb,
    ST_IDLE      = 4'hf
  } state_t;

  // Data-bit states are numbered consecutively, so the next one is code + 1.
  function automatic state_t next_bit_state(input state_t s);
    return state_t'(s + 4'd1);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// uart_rx_if: bundle of the receiver's serial input and result outputs.
// Optional member parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;

  logic       uart_rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic [3:0] state;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;

  modport master (output uart_rx, input data, valid, frame_err, parity_err, state);
  modport slave  (input uart_rx, output data, valid, frame_err, parity_err, state);
`else
  modport master (output uart_rx, input data, valid, frame_err, state);
  modport slave  (input uart_rx, output data, valid, frame_err, state);
`endif

endinterface

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous level. Both flops
// reset to 1 so an idle-high serial line does not look like a start bit.
module uart_sync2 (
  input  logic clk,
  input  logic srst,
  input  logic d,
  output logic q
);

  logic meta_reg;
  logic sync_reg;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (srst) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8-bit UART receiver, LSB first, one stop bit. Samples mid-bit by
// waiting half a bit period after the start edge, then whole periods.
// Optional feature: define UART_RX_PARITY_EN for 8E1 frames with o_parity_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       o_parity_err,
`endif
  output logic [3:0] o_state
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic             rx_s;
  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [7:0]       shift_reg, shift_next;
  logic [7:0]       data_reg, data_next;
  logic             valid_reg, valid_next;
  logic             ferr_reg, ferr_next;
  logic             bit_done;
`ifdef UART_RX_PARITY_EN
  logic             perr_reg, perr_next;
  logic             parity_ok_reg, parity_ok_next;
`endif

  uart_sync2 u_sync (
    .clk  (i_clk),
    .srst (i_reset),
    .d    (i_uart_rx),
    .q    (rx_s)
  );

  assign bit_done = (cnt_reg == BIT_LAST);

  // State, counter, shift register and registered output pulses.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      shift_reg     <= '0;
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      ferr_reg      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_reg      <= 1'b0;
      parity_ok_reg <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      shift_reg     <= shift_next;
      data_reg      <= data_next;
      valid_reg     <= valid_next;
      ferr_reg      <= ferr_next;
`ifdef UART_RX_PARITY_EN
      perr_reg      <= perr_next;
      parity_ok_reg <= parity_ok_next;
`endif
    end
  end

  // Next-state, bit timing and frame result decisions.
  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg + 1'b1;
    shift_next     = shift_reg;
    data_next      = data_reg;
    valid_next     = 1'b0;
    ferr_next      = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_next      = 1'b0;
    parity_ok_next = parity_ok_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (!rx_s) state_next = ST_START;
      end
      ST_START: begin
        // Mid start bit: a line that is high again was only a glitch.
        if (cnt_reg == HALF_LAST) begin
          cnt_next   = '0;
          state_next = rx_s ? ST_IDLE : ST_BIT_0;
        end
      end
      ST_BIT_0, ST_BIT_1, ST_BIT_2, ST_BIT_3,
      ST_BIT_4, ST_BIT_5, ST_BIT_6, ST_BIT_7: begin
        if (bit_done) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift_reg[7:1]};
          if (state_reg == ST_BIT_7) begin
`ifdef UART_RX_PARITY_EN
            state_next = ST_PARITY;
`else
            state_next = ST_STOP;
`endif
          end else begin
            state_next = next_bit_state(state_reg);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        // Even parity: data ones plus the parity bit must be even.
        if (bit_done) begin
          cnt_next       = '0;
          parity_ok_next = (rx_s == (^shift_reg));
          state_next     = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (bit_done) begin
          cnt_next = '0;
          if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            if (parity_ok_reg) begin
              data_next  = shift_reg;
              valid_next = 1'b1;
            end else begin
              perr_next = 1'b1;
            end
`else
            data_next  = shift_reg;
            valid_next = 1'b1;
`endif
            state_next = ST_IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = ST_WAIT_HIGH;
          end
        end
      end
      ST_WAIT_HIGH: begin
        // Sit out a break so it reports only one framing error.
        cnt_next = '0;
        if (rx_s) state_next = ST_IDLE;
      end
      default: begin
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
    endcase
  end

  assign o_data       = data_reg;
  assign o_valid      = valid_reg;
  assign o_frame_err  = ferr_reg;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = perr_reg;
`endif
  assign o_state      = state_reg;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx. A monitor logs every result
// pulse; each scenario task compares the log with outcomes derived from the
// frame contents. Build with UART_RX_PARITY_EN to cover the parity variant.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CLKS = 16;
  localparam int EV_VALID = 1;
  localparam int EV_FERR = 2;
  localparam int EV_PERR = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  logic [7:0] model_data = 8'h00;
  logic [7:0] prev_data = 8'h00;

  int         ev_kind[$];
  logic [7:0] ev_data[$];
  int         ev_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_if rx_if ();

  uart_rx #(.CLKS_PER_BIT(CLKS)) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_uart_rx    (rx_if.uart_rx),
    .o_data       (rx_if.data),
    .o_valid      (rx_if.valid),
    .o_frame_err  (rx_if.frame_err),
`ifdef UART_RX_PARITY_EN
    .o_parity_err (rx_if.parity_err),
`endif
    .o_state      (rx_if.state)
  );

  // Monitor: log pulses, check pulse exclusivity and that o_data only moves with o_valid.
  always @(posedge clk) begin
    #1;
    if (rx_if.valid === 1'b1) begin
      ev_kind.push_back(EV_VALID); ev_data.push_back(rx_if.data); ev_cyc.push_back(cyc);
    end
    if (rx_if.frame_err === 1'b1) begin
      ev_kind.push_back(EV_FERR); ev_data.push_back(rx_if.data); ev_cyc.push_back(cyc);
    end
`ifdef UART_RX_PARITY_EN
    if (rx_if.parity_err === 1'b1) begin
      ev_kind.push_back(EV_PERR); ev_data.push_back(rx_if.data); ev_cyc.push_back(cyc);
    end
`endif
    checks++;
    if (rx_if.valid === 1'b1 && rx_if.frame_err === 1'b1) begin
      fails++;
      $display("FAIL pulse_exclusive cycle %0d: valid and frame_err both high", cyc);
    end
    if (!rst) begin
      checks++;
      if (rx_if.valid !== 1'b1 && rx_if.data !== prev_data) begin
        fails++;
        $display("FAIL data_hold cycle %0d: o_data %h changed from %h without o_valid",
                 cyc, rx_if.data, prev_data);
      end
    end
    prev_data = rx_if.data;
  end

  // Expected outcome of one frame, straight from the frame rules.
  function automatic int exp_kind(input logic [7:0] d, input logic stop_bit, input logic par_bit);
    if (!stop_bit) return EV_FERR;
`ifdef UART_RX_PARITY_EN
    if (par_bit != (^d)) return EV_PERR;
`else
    if (par_bit === 1'bx) return EV_PERR;
`endif
    return EV_VALID;
  endfunction

  task automatic clear_events();
    ev_kind.delete(); ev_data.delete(); ev_cyc.delete();
  endtask

  task automatic drive_bit(input logic b);
    rx_if.uart_rx = b;
    repeat (CLKS) @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    rx_if.uart_rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input logic par_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_bit);
`endif
    drive_bit(stop_bit);
  endtask

  task automatic expect_single_valid(input string name, input logic [7:0] d);
    checks++;
    if (ev_kind.size() !== 1) begin
      fails++;
      $display("FAIL %s_count: got %0d pulses, want 1", name, ev_kind.size());
    end else begin
      checks++;
      if (ev_kind[0] !== EV_VALID || ev_data[0] !== d) begin
        fails++;
        $display("FAIL %s_data: got kind %0d data %h, want kind %0d data %h",
                 name, ev_kind[0], ev_data[0], EV_VALID, d);
      end
    end
    $display("frame %s: data %h pulses %0d", name, d, ev_kind.size());
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_if.uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    checks += 4;
    if (rx_if.state !== 4'hf) begin fails++; $display("FAIL reset_state: got %h want f", rx_if.state); end
    if (rx_if.data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", rx_if.data); end
    if (rx_if.valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", rx_if.valid); end
    if (rx_if.frame_err !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b want 0", rx_if.frame_err); end
    rst = 1'b0;
    idle_cycles(5);
    checks++;
    if (rx_if.state !== 4'hf) begin fails++; $display("FAIL idle_state: got %h want f", rx_if.state); end
    $display("reset: state %h data %h", rx_if.state, rx_if.data);
  endtask

  task automatic test_latency();
    int t0;
    int lat;
    clear_events();
    t0 = cyc;
    send_frame(8'h48, 1'b1, ^8'h48);
    idle_cycles(CLKS);
    expect_single_valid("latency_48", 8'h48);
    model_data = 8'h48;
    if (ev_cyc.size() > 0) begin
      lat = ev_cyc[0] - t0;
      checks++;
      if (lat < 153 || lat > 155) begin
        fails++;
        $display("FAIL latency: got %0d cycles, want 154 +/-1", lat);
      end
      $display("latency: %0d cycles", lat);
    end
  endtask

  task automatic test_glitch();
    clear_events();
    rx_if.uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    idle_cycles(3 * CLKS);
    checks += 3;
    if (rx_if.state !== 4'hf) begin fails++; $display("FAIL glitch_state: got %h want f", rx_if.state); end
    if (ev_kind.size() !== 0) begin fails++; $display("FAIL glitch_pulses: got %0d want 0", ev_kind.size()); end
    if (rx_if.data !== model_data) begin fails++; $display("FAIL glitch_data: got %h want %h", rx_if.data, model_data); end
    $display("glitch: state %h pulses %0d", rx_if.state, ev_kind.size());
  endtask

  task automatic test_break();
    clear_events();
    send_frame(8'h55, 1'b0, ^8'h55);
    repeat (40 * CLKS) @(negedge clk);
    checks += 4;
    if (rx_if.state !== 4'hb) begin fails++; $display("FAIL break_state: got %h want b", rx_if.state); end
    if (ev_kind.size() !== 1) begin
      fails++; $display("FAIL break_pulses: got %0d want 1", ev_kind.size());
    end else if (ev_kind[0] !== EV_FERR) begin
      fails++; $display("FAIL break_kind: got %0d want %0d", ev_kind[0], EV_FERR);
    end
    if (rx_if.data !== model_data) begin fails++; $display("FAIL break_data: got %h want %h", rx_if.data, model_data); end
    idle_cycles(4);
    if (rx_if.state !== 4'hf) begin fails++; $display("FAIL break_release: got %h want f", rx_if.state); end
    $display("break: pulses %0d data %h", ev_kind.size(), rx_if.data);
    clear_events();
    send_frame(8'hA5, 1'b1, ^8'hA5);
    idle_cycles(CLKS);
    expect_single_valid("after_break_a5", 8'hA5);
    model_data = 8'hA5;
  endtask

  task automatic test_back_to_back();
    clear_events();
    send_frame(8'h00, 1'b1, ^8'h00);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    idle_cycles(CLKS);
    checks++;
    if (ev_kind.size() !== 2) begin
      fails++; $display("FAIL b2b_count: got %0d want 2", ev_kind.size());
    end else begin
      checks++;
      if (ev_kind[0] !== EV_VALID || ev_data[0] !== 8'h00 ||
          ev_kind[1] !== EV_VALID || ev_data[1] !== 8'hFF) begin
        fails++;
        $display("FAIL b2b_data: got %0d/%h %0d/%h want 1/00 1/ff",
                 ev_kind[0], ev_data[0], ev_kind[1], ev_data[1]);
      end
    end
    model_data = 8'hFF;
    $display("back_to_back: pulses %0d", ev_kind.size());
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'h3C;
    clear_events();
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    rx_if.uart_rx = d[3];
    repeat (CLKS / 2) @(negedge clk);
    checks++;
    if (rx_if.state !== 4'h4) begin fails++; $display("FAIL midframe_state: got %h want 4", rx_if.state); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_if.state !== 4'hf) begin fails++; $display("FAIL midframe_reset_state: got %h want f", rx_if.state); end
    rst = 1'b0;
    model_data = 8'h00;
    idle_cycles(3 * CLKS);
    checks += 2;
    if (ev_kind.size() !== 0) begin fails++; $display("FAIL midframe_pulses: got %0d want 0", ev_kind.size()); end
    if (rx_if.data !== 8'h00) begin fails++; $display("FAIL midframe_data: got %h want 00", rx_if.data); end
    $display("reset_midframe: pulses %0d", ev_kind.size());
    clear_events();
    send_frame(8'hC3, 1'b1, ^8'hC3);
    idle_cycles(CLKS);
    expect_single_valid("after_reset_c3", 8'hC3);
    model_data = 8'hC3;
  endtask

  task automatic test_random();
    int         exp_k[$];
    logic [7:0] exp_d[$];
    logic [7:0] d;
    logic       sb;
    logic       pb;
    clear_events();
    for (int n = 0; n < 10; n++) begin
      d  = 8'($urandom_range(0, 255));
      sb = ($urandom_range(0, 3) != 0);
`ifdef UART_RX_PARITY_EN
      pb = ($urandom_range(0, 2) == 0) ? ~(^d) : (^d);
`else
      pb = ^d;
`endif
      exp_k.push_back(exp_kind(d, sb, pb));
      exp_d.push_back(d);
      send_frame(d, sb, pb);
      if (exp_kind(d, sb, pb) == EV_VALID) model_data = d;
      $display("random frame %0d: data %h stop %b parity %b expect %0d", n, d, sb, pb, exp_k[n]);
      idle_cycles(sb ? $urandom_range(0, CLKS) : 2 * CLKS);
    end
    idle_cycles(CLKS);
    checks++;
    if (ev_kind.size() !== exp_k.size()) begin
      fails++; $display("FAIL random_count: got %0d want %0d", ev_kind.size(), exp_k.size());
    end else begin
      for (int i = 0; i < exp_k.size(); i++) begin
        checks++;
        if (ev_kind[i] !== exp_k[i] || (exp_k[i] == EV_VALID && ev_data[i] !== exp_d[i])) begin
          fails++;
          $display("FAIL random_frame_%0d: got kind %0d data %h want kind %0d data %h",
                   i, ev_kind[i], ev_data[i], exp_k[i], exp_d[i]);
        end
      end
    end
    checks++;
    if (rx_if.data !== model_data) begin
      fails++; $display("FAIL random_final_data: got %h want %h", rx_if.data, model_data);
    end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_events();
    send_frame(8'h07, 1'b1, 1'b0);
    idle_cycles(CLKS);
    checks++;
    if (ev_kind.size() !== 1 || ev_kind[0] !== EV_PERR) begin
      fails++; $display("FAIL parity_bad: got %0d pulses, want one parity_err", ev_kind.size());
    end
    checks++;
    if (rx_if.data !== model_data) begin
      fails++; $display("FAIL parity_bad_data: got %h want %h", rx_if.data, model_data);
    end
    $display("parity bad: pulses %0d", ev_kind.size());
    clear_events();
    send_frame(8'h07, 1'b1, 1'b1);
    idle_cycles(CLKS);
    expect_single_valid("parity_good_07", 8'h07);
    model_data = 8'h07;
  endtask
`endif

  initial begin
    rx_if.uart_rx = 1'b1;
    test_reset();
    test_latency();
    test_glitch();
    test_break();
    test_back_to_back();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning i_clk cycles per UART bit period; legal values are 4 to 65535.
REQ-002 SHALL have port i_clk, input, 1 bit: the only clock; all logic is on its rising edge.
REQ-003 SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port i_uart_rx, input, 1 bit: asynchronous serial line; idles high.
REQ-005 SHALL have port o_data, output, 8 bits: last received byte.
REQ-006 SHALL have port o_valid, output, 1 bit: one-cycle pulse marking a new good byte on o_data.
REQ-007 SHALL have port o_frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-008 SHALL have port o_state, output, 4 bits: current FSM state code.

Function
REQ-009 SHALL pass i_uart_rx through a 2-flop synchronizer; all decisions use the synchronized value (rx_s), and both flops reset to 1.
REQ-010 SHALL implement these FSM states and codes: IDLE=4'hf, START=4'h0, BIT_0..BIT_7=4'h1..4'h8, PARITY=4'h9, STOP=4'ha, WAIT_HIGH=4'hb.
REQ-011 IDLE: when rx_s==0, the FSM SHALL enter START and clear the bit counter.
REQ-012 START: after CLKS_PER_BIT/2 cycles (integer division), the FSM SHALL resample rx_s; if 0, it SHALL go to BIT_0; if 1 (glitch/false start), it SHALL return to IDLE with no output pulse.
REQ-013 BIT_n states: each SHALL sample rx_s exactly CLKS_PER_BIT cycles after the previous sample point, shift it in LSB-first, and then advance.
REQ-014 After BIT_7, the FSM SHALL go to STOP, or to PARITY when UART_RX_PARITY_EN is defined.
REQ-015 STOP sample = 1: o_data SHALL be loaded and o_valid pulsed for exactly one cycle, in the cycle after the sample point; the FSM SHALL then return to IDLE.
REQ-016 STOP sample = 0: o_frame_err SHALL pulse for one cycle, o_valid SHALL stay 0, o_data SHALL keep its old value, and the FSM SHALL enter WAIT_HIGH.
REQ-017 WAIT_HIGH: the FSM SHALL remain until rx_s==1, then go to IDLE; a held-low line (break) SHALL produce exactly one o_frame_err.
REQ-018 o_data SHALL change only together with o_valid and SHALL hold its value otherwise.
REQ-019 The bit-period counter SHALL be at least clog2(CLKS_PER_BIT) bits wide, SHALL count from 0 to CLKS_PER_BIT-1 and reset to 0, and SHALL never wrap mid-bit.
REQ-020 The block SHALL accept back-to-back frames: a start edge detected in IDLE in the cycle after STOP SHALL be received.
REQ-021 o_valid and o_frame_err SHALL never both be high in the same cycle.

Reset
REQ-022 When i_reset is high, the block SHALL set o_state=IDLE, o_data=8'h00, o_valid=0, o_frame_err=0, and clear all counters and the shift register, with synchronizer flops set to 1.
REQ-023 Reset mid-frame SHALL abort the frame with no pulse; the first frame whose start bit begins after reset deasserts SHALL be received normally.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: the block SHALL add state PARITY, sampled one bit period after BIT_7, using even parity over the 8 data bits.
REQ-025 With UART_RX_PARITY_EN defined, the block SHALL add output o_parity_err (1 bit, reset 0), pulsed in place of o_valid on a parity mismatch with a good stop bit; o_data SHALL not update in that case.
REQ-026 Macro UART_RX_PARITY_EN undefined: the block SHALL have no PARITY state and no o_parity_err port, and the frame SHALL be 8N1.

Structure
REQ-027 Package uart_pkg SHALL hold the state code constants (shared with the transmitter) and the default bit period constant of 16.
REQ-028 The block SHALL use one sub-module, uart_sync2 (2-flop synchronizer with reset value 1); everything else SHALL be in uart_rx.

Verification
REQ-029 Scenario: CLKS_PER_BIT=16, send 8N1 frame 0x48 ('H') -> exactly one o_valid, with o_data=0x48, 2+8+(9*16) cycles after the start falling edge, within +/-1 cycle.
REQ-030 Scenario: 4-cycle low glitch on an idle line -> FSM returns to IDLE, no o_valid, no o_frame_err.
REQ-031 Scenario: frame 0x55 with stop bit forced 0, then line held low for 40 bit periods -> one o_frame_err, o_data unchanged, o_state=4'hb until the line goes high, then a following 0xA5 frame is received correctly.
REQ-032 Scenario: back-to-back frames 0x00 and 0xFF with no idle gap -> two o_valid pulses, carrying 0x00 and then 0xFF.
REQ-033 Scenario: i_reset asserted during BIT_3 of frame 0x3C -> no pulse, o_state=IDLE in the next cycle, and a subsequent frame 0xC3 gives o_data=0xC3.
REQ-034 Scenario (UART_RX_PARITY_EN): frame 0x07 with parity bit 0 -> o_parity_err pulse and no o_valid; the same frame with parity bit 1 -> o_valid with o_data=0x07.
